// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle for mem_arbiter. The arbiter takes the
// slave modport; the requesters/memory environment takes the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  // Handshake: a requester raises reqN with rwN/addrN/wdataN and holds all of
  // them constant until ackN pulses for one cycle; rdata is valid only while
  // that ack is high. A request dropped after being granted still completes.
  logic                  req0;
  logic                  rw0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic                  req1;
  logic                  rw1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  owner;
  logic                  busy;
  logic                  mem_rw;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_q,
    output ack0, ack1, rdata, owner, busy, mem_rw, mem_addr, mem_data
  );

  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_q,
    input  ack0, ack1, rdata, owner, busy, mem_rw, mem_addr, mem_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Each access runs IDLE -> ACCESS -> RESP with all memory-side signals registered.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  logic                  rr;
  logic                  grant1;
  logic                  rw_w;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] wdata_w;
  logic                  ack0_r;
  logic                  ack1_r;
  logic                  owner_r;
  logic                  busy_r;
  logic                  mem_rw_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_data_r;

  // On contention rr names the port to favour; a lone request always wins.
  always_comb begin
    grant1 = bus.req1;
    if (bus.req0 && bus.req1) begin
      grant1 = (FIXED_PRIO != 0) ? 1'b0 : rr;
    end
    rw_w    = grant1 ? bus.rw1    : bus.rw0;
    addr_w  = grant1 ? bus.addr1  : bus.addr0;
    wdata_w = grant1 ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      ack0_r     <= 1'b0;
      ack1_r     <= 1'b0;
      owner_r    <= 1'b0;
      busy_r     <= 1'b0;
      mem_rw_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          if (bus.req0 || bus.req1) begin
            owner_r    <= grant1;
            rr         <= ~grant1;
            mem_rw_r   <= rw_w;
            mem_addr_r <= addr_w;
            if (rw_w) begin
              mem_data_r <= wdata_w;
            end
            busy_r     <= 1'b1;
            state      <= ACCESS;
          end else begin
            mem_rw_r <= 1'b0;
          end
        end
        ACCESS: begin
          // The memory acts on this closing edge, so the write strobe ends here.
          mem_rw_r <= 1'b0;
          ack0_r   <= ~owner_r;
          ack1_r   <= owner_r;
          state    <= RESP;
        end
        RESP: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          busy_r   <= 1'b0;
          mem_rw_r <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Memory output is already registered, so it is forwarded only in RESP.
  assign bus.rdata    = (state == RESP) ? bus.mem_q : '0;
  assign bus.ack0     = ack0_r;
  assign bus.ack1     = ack1_r;
  assign bus.owner    = owner_r;
  assign bus.busy     = busy_r;
  assign bus.mem_rw   = mem_rw_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_data = mem_data_r;
  assign state_dbg    = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin instance with a memory model and scoreboard,
// plus a fixed-priority instance for the starvation case.
module tb_mem_arbiter;

  localparam int SBW = 10;   // {port, is_read, data}

  typedef struct {
    bit          port;
    bit          rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] state_rr;
  logic [1:0] state_fp;
  int         checks;
  int         errors;
  int         wr_cycles;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  logic [SBW-1:0] exp_q[$];
  logic [7:0]     ref_mem[int];
  logic [7:0]     mem_rr[65536];
  bit             written[65536];

  mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_rr ();
  mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_fp ();

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .bus(bus_rr), .state_dbg(state_rr)
  );

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .bus(bus_fp), .state_dbg(state_fp)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] iv(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return iv(a);
  endfunction

  // Synchronous single-port memory: registered q, read-before-write.
  always @(posedge clk) begin
    if (bus_rr.mem_rw) begin
      mem_rr[bus_rr.mem_addr]  <= bus_rr.mem_data;
      written[bus_rr.mem_addr] <= 1'b1;
    end
    bus_rr.mem_q <= written[bus_rr.mem_addr] ? mem_rr[bus_rr.mem_addr] : iv(bus_rr.mem_addr);
  end

  always @(posedge clk) bus_fp.mem_q <= iv(bus_fp.mem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [SBW-1:0] e;
    if (rst) begin
      if (bus_rr.ack0 || bus_rr.ack1) begin
        chk("ack_exclusive", {bus_rr.ack0, bus_rr.ack1}, (bus_rr.ack1 ? 2'b01 : 2'b10));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack actual=ack required=none");
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", bus_rr.ack1, e[9]);
          chk("owner", bus_rr.owner, e[9]);
          chk("busy_resp", bus_rr.busy, 1);
          if (e[8]) chk("rdata", bus_rr.rdata, e[7:0]);
        end
      end
      if (bus_rr.mem_rw) begin
        chk("mem_rw_in_access", state_rr, 2'd1);
        wr_cycles++;
        wr_addr = bus_rr.mem_addr;
        wr_data = bus_rr.mem_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_any_ack(input bit fp, input int limit, output int n);
    bit got;
    n = 0;
    got = 0;
    while (!got && n < limit) begin
      @(posedge clk); #1;
      n++;
      got = fp ? (bus_fp.ack0 | bus_fp.ack1) : (bus_rr.ack0 | bus_rr.ack1);
    end
    if (!got) n = -1;
  endtask

  task automatic access(input bit port, input bit rw, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd);
    int n;
    @(posedge clk); #1;
    if (port) begin
      bus_rr.req1 = 1'b1; bus_rr.rw1 = rw; bus_rr.addr1 = addr; bus_rr.wdata1 = wdata;
    end else begin
      bus_rr.req0 = 1'b1; bus_rr.rw0 = rw; bus_rr.addr0 = addr; bus_rr.wdata0 = wdata;
    end
    exp_q.push_back({port, ~rw, rw ? 8'h00 : exp_rd});
    if (rw) ref_mem[int'(addr)] = wdata;
    wait_any_ack(1'b0, 20, n);
    chk("latency", n, 2);
    bus_rr.req0 = 1'b0;
    bus_rr.req1 = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[6];
    int   n;
    int   n0;
    bit   p;
    bit   w;
    logic [15:0] a;
    logic [7:0]  d;

    vecs[0] = '{port: 0, rw: 1, addr: 16'h0010, wdata: 8'hA5, exp_rd: 8'h00};
    vecs[1] = '{port: 0, rw: 0, addr: 16'h0010, wdata: 8'h00, exp_rd: 8'hA5};
    vecs[2] = '{port: 1, rw: 0, addr: 16'h0010, wdata: 8'h00, exp_rd: 8'hA5};
    vecs[3] = '{port: 1, rw: 1, addr: 16'h1234, wdata: 8'h5A, exp_rd: 8'h00};
    vecs[4] = '{port: 0, rw: 0, addr: 16'h1234, wdata: 8'h00, exp_rd: 8'h5A};
    vecs[5] = '{port: 0, rw: 0, addr: 16'h0001, wdata: 8'h00, exp_rd: 8'h5B};

    checks = 0; errors = 0; wr_cycles = 0;
    rst = 1'b0;
    bus_rr.req0 = 0; bus_rr.rw0 = 0; bus_rr.addr0 = '0; bus_rr.wdata0 = '0;
    bus_rr.req1 = 0; bus_rr.rw1 = 0; bus_rr.addr1 = '0; bus_rr.wdata1 = '0;
    bus_fp.req0 = 0; bus_fp.rw0 = 0; bus_fp.addr0 = '0; bus_fp.wdata0 = '0;
    bus_fp.req1 = 0; bus_fp.rw1 = 0; bus_fp.addr1 = '0; bus_fp.wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {bus_rr.ack0, bus_rr.ack1, bus_rr.owner, bus_rr.busy, bus_rr.mem_rw, state_rr}, 0);
    chk("reset_data", {bus_rr.rdata, bus_rr.mem_addr, bus_rr.mem_data}, 0);
    chk("reset_fp", {bus_fp.ack0, bus_fp.ack1, bus_fp.busy, bus_fp.mem_rw, bus_fp.mem_addr, state_fp}, 0);

    // Both ports requesting out of reset: round-robin 0,1,0,1 every 3 cycles.
    bus_rr.req0 = 1; bus_rr.addr0 = 16'h0001;
    bus_rr.req1 = 1; bus_rr.addr1 = 16'h0002;
    for (int k = 0; k < 4; k++) exp_q.push_back({k[0], 1'b1, iv(k[0] ? 16'h0002 : 16'h0001)});
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(1'b0, 10, n);
      chk("rr_spacing", n, (k == 0) ? 2 : 3);
      chk("rr_order", bus_rr.ack1, k[0]);
    end
    bus_rr.req0 = 0; bus_rr.req1 = 0;

    // Fixed priority: port 0 wins while held; port 1 follows once it drops.
    @(posedge clk); #1;
    bus_fp.req0 = 1; bus_fp.addr0 = 16'h0001;
    bus_fp.req1 = 1; bus_fp.addr1 = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(1'b1, 10, n);
      chk("fp_spacing", n, (k == 0) ? 2 : 3);
      chk("fp_port0_only", {bus_fp.ack0, bus_fp.ack1}, 2'b10);
      chk("fp_rdata0", bus_fp.rdata, iv(16'h0001));
    end
    bus_fp.req0 = 0;
    wait_any_ack(1'b1, 3, n);
    chk("fp_ack1_within3", (n >= 1) && (n <= 3), 1);
    chk("fp_ack1", {bus_fp.ack0, bus_fp.ack1}, 2'b01);
    chk("fp_rdata1", bus_fp.rdata, iv(16'h0002));
    bus_fp.req1 = 0;

    // Table-driven accesses.
    for (int i = 0; i < 6; i++) begin
      access(vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
    end

    // Port 1 write: one-cycle strobe with unmodified address/data, then read back.
    n0 = wr_cycles;
    access(1'b1, 1'b1, 16'h00FF, 8'h3C, 8'h00);
    chk("wr_pulse_len", wr_cycles - n0, 1);
    chk("wr_addr", wr_addr, 16'h00FF);
    chk("wr_data", wr_data, 8'h3C);
    access(1'b0, 1'b0, 16'h00FF, 8'h00, 8'h3C);

    // Reset during ACCESS of a read: outputs clear at once, no ack.
    @(posedge clk); #1;
    bus_rr.req0 = 1; bus_rr.rw0 = 0; bus_rr.addr0 = 16'h0010;
    @(posedge clk); #1;
    chk("pre_reset_access", state_rr, 2'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_ctrl", {bus_rr.ack0, bus_rr.ack1, bus_rr.owner, bus_rr.busy, bus_rr.mem_rw, state_rr}, 0);
    chk("midrst_data", {bus_rr.rdata, bus_rr.mem_addr, bus_rr.mem_data}, 0);
    bus_rr.req0 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    access(1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5);

    // Address changed during ACCESS is ignored.
    @(posedge clk); #1;
    bus_rr.req0 = 1; bus_rr.rw0 = 0; bus_rr.addr0 = 16'h0020;
    exp_q.push_back({1'b0, 1'b1, iv(16'h0020)});
    @(posedge clk); #1;
    bus_rr.addr0 = 16'h0030;
    chk("addr_captured", bus_rr.mem_addr, 16'h0020);
    wait_any_ack(1'b0, 10, n);
    chk("addr_change_latency", n, 1);
    bus_rr.req0 = 0;

    // Random traffic checked against the reference memory.
    for (int i = 0; i < 12; i++) begin
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 16'h0100 + 16'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      access(p, w, a, d, w ? 8'h00 : ref_rd(a));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
